// File: rtl/regfile_wr_arb_pkg.sv
// rtl/regfile_wr_arb_pkg.sv - shared constants and requester ids for the register-file write arbiter
package regfile_wr_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_t;

endpackage

// File: rtl/regsel_decode.sv
// rtl/regsel_decode.sv - register address to one-hot write-enable decoder with enable
module regsel_decode
  import regfile_wr_arb_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] addr,
  output logic [NREG-1:0]       onehot
);

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NREG; k++) begin
      if (en && (32'(addr) == k)) onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - two-requester register-file write arbiter with registered write beat
// REGARB_ROUNDROBIN_EN: defined selects round-robin ties; undefined gives the load port fixed priority.
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [REG_ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0]     req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [REG_ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0]     req1_data,
  input  logic                  hold,
  output logic [NREG-1:0]       Dselect,
  output logic [DATA_W-1:0]     dbus,
  output logic                  grant_id,
  output logic [15:0]           wr_count
);

  req_id_t               win_id;
  req_id_t               tie_pick;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0]     win_data;
  logic [NREG-1:0]       dsel_next;
  logic [NREG-1:0]       dsel_q;

`ifdef REGARB_ROUNDROBIN_EN
  req_id_t last_grant;

  assign tie_pick = (last_grant == REQ_LOAD) ? REQ_ALU : REQ_LOAD;

  // Reset to LOAD so the ALU port takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_grant <= REQ_LOAD;
    else if (xfer) last_grant <= win_id;
  end
`else
  assign tie_pick = REQ_LOAD;
`endif

  always_comb begin
    win_id = REQ_ALU;
    if (req0_valid && req1_valid) win_id = tie_pick;
    else if (req1_valid) win_id = REQ_LOAD;
  end

  assign req0_ready = !reset && !hold && req0_valid && (win_id == REQ_ALU);
  assign req1_ready = !reset && !hold && req1_valid && (win_id == REQ_LOAD);
  assign xfer       = req0_ready || req1_ready;
  assign win_addr   = (win_id == REQ_LOAD) ? req1_addr : req0_addr;
  assign win_data   = (win_id == REQ_LOAD) ? req1_data : req0_data;

  regsel_decode #(
    .NREG(NREG)
  ) u_regsel_decode (
    .en    (xfer && (win_addr != ZERO_REG)),
    .addr  (win_addr),
    .onehot(dsel_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dsel_q   <= '0;
      dbus     <= '0;
      grant_id <= 1'b0;
      wr_count <= '0;
    end else begin
      dsel_q <= dsel_next;
      if (xfer) begin
        dbus     <= win_data;
        grant_id <= win_id;
      end
      if ((|Dselect) && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
    end
  end

  // A beat registered just before reset is dropped while reset is high.
  assign Dselect = reset ? '0 : dsel_q;

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 Parameter DATA_W, default 32, width of write data and dbus.
REQ-002 Parameter NREG, default 32, number of registers; width of the one-hot Dselect.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk  in  1  rising-edge clock shared with the register file.
REQ-005 Port reset  in  1  synchronous active-high reset.
REQ-006 Port req0_valid  in  1  requester 0 (ALU writeback) has a write pending.
REQ-007 Port req0_ready  out  1  requester 0 write accepted this cycle.
REQ-008 Port req0_addr  in  5  destination register of requester 0.
REQ-009 Port req0_data  in  DATA_W  write data of requester 0.
REQ-010 Ports req1_valid, req1_ready, req1_addr, req1_data: same widths and meanings for requester 1 (load writeback).
REQ-011 Port hold  in  1  pipeline freeze; no grants while high.
REQ-012 Port Dselect  out  NREG  one-hot write enable to the register file.
REQ-013 Port dbus  out  DATA_W  write data to the register file.
REQ-014 Port grant_id  out  1  requester that owns the current Dselect/dbus beat.
REQ-015 Port wr_count  out  16  saturating count of committed non-zero-register writes.

Function
REQ-016 A transfer SHALL occur on requester i in a cycle where reqi_valid=1 and reqi_ready=1.
REQ-017 reqi_ready SHALL be combinational.
REQ-018 reqi_ready SHALL be 1 only when hold=0, reset=0, reqi_valid=1 and requester i wins arbitration.
REQ-019 At most one ready SHALL be high per cycle.
REQ-020 Requesters SHALL hold valid, addr and data stable until ready is seen.
REQ-021 A transfer in cycle N SHALL drive Dselect, dbus and grant_id from registers in cycle N+1 only (latency 1).
REQ-022 In cycle N+1, Dselect SHALL be the one-hot decode of addr, with bit k set when addr = k.
REQ-023 In cycle N+1, dbus SHALL equal the accepted data.
REQ-024 In any cycle with no transfer in the previous cycle, Dselect SHALL be all zero.
REQ-025 In that case dbus and grant_id SHALL hold their last value.
REQ-026 Write to addr 0: the transfer completes normally and Dselect stays all zero in N+1.
REQ-027 Write to addr 0: wr_count is not incremented.
REQ-028 Arbitration with one requester valid: that requester SHALL be granted.
REQ-029 Arbitration with both requesters valid: the requester not granted last SHALL be granted (round-robin).
REQ-030 Round-robin SHALL hold regardless of whether the two addresses are equal.
REQ-031 The losing requester SHALL stay pending and be granted next cycle if hold=0.
REQ-032 Last-grant state SHALL update only on a transfer.
REQ-033 hold=1 SHALL suppress new transfers.
REQ-034 A beat already registered when hold rises SHALL still be presented (no beat lost).
REQ-035 wr_count SHALL increment in the cycle Dselect is non-zero.
REQ-036 wr_count SHALL saturate at 16'hFFFF.

Reset
REQ-037 When reset=1 at a rising edge, Dselect SHALL be 0 after that edge.
REQ-038 When reset=1 at a rising edge, dbus, grant_id and wr_count SHALL be 0 after that edge.
REQ-039 When reset=1 at a rising edge, last-grant state SHALL be set so requester 0 wins the first tie.
REQ-040 While reset=1, both ready outputs SHALL be 0.
REQ-041 A beat accepted in the cycle before reset SHALL be discarded: Dselect is 0 in the reset cycle.

Configuration
REQ-042 Macro REGARB_ROUNDROBIN_EN defined: arbitration SHALL follow REQ-029 to REQ-032.
REQ-043 Macro REGARB_ROUNDROBIN_EN undefined: requester 1 (load) SHALL always win ties.
REQ-044 Macro REGARB_ROUNDROBIN_EN undefined: no last-grant state SHALL be implemented.

Structure
REQ-045 A shared package SHALL hold REG_ADDR_W=5, ZERO_REG=0 and the requester-id typedef (REQ_ALU=0, REQ_LOAD=1).
REQ-046 The one-hot decoder SHALL be one sub-module, regsel_decode (5-bit in, NREG one-hot out, enable input).

Verification
REQ-047 Scenario: after reset, req0 valid with addr=3, data=32'h0000_00AA -> ready0=1 in N; Dselect=32'h0000_0008, dbus=32'hAA, grant_id=0 in N+1; wr_count=1.
REQ-048 Scenario: both valid for 4 cycles, addr 5 and 6 -> grants 0,1,0,1 (round-robin); with macro undefined, grants 1,1,1,1.
REQ-049 Scenario: req1 write to addr 0, data 32'hFFFF_FFFF -> ready1=1, then Dselect=0 and wr_count unchanged.
REQ-050 Scenario: hold=1 for 3 cycles with both valid -> no ready for 3 cycles, Dselect=0 from the second hold cycle; grants resume the cycle hold falls.
REQ-051 Scenario: reset asserted the cycle after a transfer to addr 7 -> Dselect=0, wr_count=0, ready0=ready1=0.
REQ-052 Scenario: wr_count preloaded near saturation by 65540 writes -> wr_count stays 16'hFFFF.
